// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register addresses,
// vector field layout and the fixed index width.
package irq_ctrl_pkg;

   localparam int IDX_W = 5;

   localparam logic [1:0] ADDR_PENDING = 2'd0;
   localparam logic [1:0] ADDR_MASK    = 2'd1;
   localparam logic [1:0] ADDR_ACTIVE  = 2'd2;
   localparam logic [1:0] ADDR_VECTOR  = 2'd3;

   localparam int VEC_VALID_BIT = 31;

endpackage : irq_ctrl_pkg

// File: rtl/irq_ctrl_if.sv
// Chip-select slave bus shared by the memory-mapped peripherals.
// The CPU side is the master; irq_ctrl is a slave.
interface irq_ctrl_if;

   logic        s_cs_n;
   logic [1:0]  s_address;
   logic        s_read;
   logic [31:0] s_readdata;
   logic        s_write;
   logic [31:0] s_writedata;

   modport master (
      output s_cs_n,
      output s_address,
      output s_read,
      output s_write,
      output s_writedata,
      input  s_readdata
   );

   modport slave (
      input  s_cs_n,
      input  s_address,
      input  s_read,
      input  s_write,
      input  s_writedata,
      output s_readdata
   );

endinterface : irq_ctrl_if

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set index wins.
// idx is 0 when no request is set; valid qualifies it.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_IRQ = 8
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule : irq_prio_enc

// File: rtl/irq_ctrl.sv
// Interrupt controller: rising-edge capture of peripheral irq levels into a
// W1C pending register, per-source mask, registered irq_out to the CPU and
// a VECTOR register giving the highest-priority (lowest index) active source.
// Optional macro IRQ_CTRL_SYNC_EN inserts a 2-flop synchronizer on irq_in
// ahead of edge detection for sources on other clock domains.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   irq_ctrl_if.slave          bus,
   output logic               irq_out
);

   logic [NUM_IRQ-1:0] irq_src;
   logic [NUM_IRQ-1:0] irq_prev_reg;
   logic [NUM_IRQ-1:0] edge_vec;
   logic [NUM_IRQ-1:0] clr_vec;
   logic [NUM_IRQ-1:0] pending_reg;
   logic [NUM_IRQ-1:0] pending_next;
   logic [NUM_IRQ-1:0] mask_reg;
   logic [NUM_IRQ-1:0] active;
   logic               irq_out_reg;
   logic [31:0]        readdata_reg;
   logic [31:0]        rd_data;
   logic               wr_en;
   logic               rd_en;
   logic               vec_valid;
   logic [IDX_W-1:0]   vec_idx;

`ifdef IRQ_CTRL_SYNC_EN
   logic [NUM_IRQ-1:0] sync1_reg;
   logic [NUM_IRQ-1:0] sync2_reg;

   // Two-stage synchronizer for asynchronous interrupt sources.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= irq_in;
         sync2_reg <= sync1_reg;
      end
   end

   assign irq_src = sync2_reg;
`else
   assign irq_src = irq_in;
`endif

   assign wr_en = ~bus.s_cs_n & bus.s_write;
   assign rd_en = ~bus.s_cs_n & bus.s_read;

   // Only rising edges are captured; a held level is seen once.
   assign edge_vec = irq_src & ~irq_prev_reg;
   assign clr_vec  = (wr_en && (bus.s_address == ADDR_PENDING))
                     ? bus.s_writedata[NUM_IRQ-1:0] : '0;

   // Per-source pending next state: a new edge beats a same-cycle clear.
   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pending
         assign pending_next[gi] = edge_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
      end
   endgenerate

   assign active = pending_reg & mask_reg;

   irq_prio_enc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio_enc (
      .req   (active),
      .valid (vec_valid),
      .idx   (vec_idx)
   );

   // Edge history, pending, mask and the CPU interrupt line.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_prev_reg <= '0;
         pending_reg  <= '0;
         mask_reg     <= '0;
         irq_out_reg  <= 1'b0;
      end else begin
         irq_prev_reg <= irq_src;
         pending_reg  <= pending_next;
         if (wr_en && (bus.s_address == ADDR_MASK)) begin
            mask_reg <= bus.s_writedata[NUM_IRQ-1:0];
         end
         irq_out_reg <= |active;
      end
   end

   // Read mux from current register state, so a read sees pre-write values.
   always_comb begin
      rd_data = '0;
      case (bus.s_address)
         ADDR_PENDING: rd_data[NUM_IRQ-1:0] = pending_reg;
         ADDR_MASK:    rd_data[NUM_IRQ-1:0] = mask_reg;
         ADDR_ACTIVE:  rd_data[NUM_IRQ-1:0] = active;
         ADDR_VECTOR: begin
            rd_data[VEC_VALID_BIT] = vec_valid;
            rd_data[IDX_W-1:0]     = vec_idx;
         end
      endcase
   end

   // Registered read data; holds its value between reads.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         readdata_reg <= '0;
      end else if (rd_en) begin
         readdata_reg <= rd_data;
      end
   end

   assign bus.s_readdata = readdata_reg;
   assign irq_out        = irq_out_reg;

endmodule : irq_ctrl
